// File: rtl/qspi_tx_serializer_if.sv
// Purpose : groups the sequencer/FIFO-facing handshake and the QSPI pin bundle of qspi_tx_serializer.
// Ports   : master = sequencer/FIFO side (drives start, mode, count, FIFO flags/data).
//           slave  = serializer side (drives FIFO pop, sclk, io lanes, status).
interface qspi_tx_serializer_if;
   logic        start;       // 1-cycle start pulse from the sequencer
   logic        quad_mode;   // 1 = 4 lanes, 0 = IO0 only
   logic [8:0]  word_count;  // words in this program-data phase (0..256)
   logic        fifo_empty;  // TX FIFO empty flag
   logic        fifo_rd_en;  // TX FIFO pop request
   logic [31:0] fifo_data;   // TX FIFO read data, valid the cycle after a pop
   logic        sclk;        // QSPI serial clock, mode 0
   logic [3:0]  io_out;      // lane data
   logic [3:0]  io_oe;       // lane output enables
   logic        busy;        // transfer in progress
   logic        done;        // 1-cycle completion pulse
   logic        stall;       // sticky underrun flag

   modport master (
      output start, quad_mode, word_count, fifo_empty, fifo_data,
      input  fifo_rd_en, sclk, io_out, io_oe, busy, done, stall
   );

   modport slave (
      input  start, quad_mode, word_count, fifo_empty, fifo_data,
      output fifo_rd_en, sclk, io_out, io_oe, busy, done, stall
   );
endinterface

// File: rtl/qspi_tx_serializer.sv
// Purpose : pops 32-bit words from the TX FIFO and shifts them MSB-first onto IO0 or IO3..IO0, SPI mode 0.
// Latency : per word 2 clk (fetch+load) + 2*CLK_DIV*(8 quad | 32 single) clk; done 1 clk after last fall.
// Backpr. : an empty FIFO holds the fetch with sclk low; a mid-transfer hold sets the sticky stall flag.
// Ports   : clk, rst_n (async active-low); bus (slave modport): start/quad_mode/word_count in,
//           fifo_empty/fifo_data in, fifo_rd_en out, sclk/io_out/io_oe out, busy/done/stall out.
module qspi_tx_serializer #(
   parameter int CLK_DIV = 2,
   parameter int WORD_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   qspi_tx_serializer_if.slave  bus
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [WORD_W-1:0]   r_sreg;
   logic [DIV_W-1:0]    r_div;
   logic [4:0]          r_bit;     // SCLK periods completed within the current word
   logic [8:0]          r_rem;     // words still to send
   logic                r_quad;
   logic                r_sclk;
   logic                r_first;   // next fetch is the first of the transfer
   logic                r_stall;

   logic                w_div_end;
   logic                w_fall;
   logic                w_last_bit;
   logic                w_rd_en;
   logic                w_busy;
   logic                w_done;
   logic [3:0]          w_io_out;
   logic [3:0]          w_io_oe;

   assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
   // r_sclk high at the end of a half-period means this edge is a falling edge
   assign w_fall     = (r_state == S_SHIFT) && w_div_end && r_sclk;
   assign w_last_bit = r_quad ? (r_bit == 5'd7) : (r_bit == 5'd31);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_rd_en  = 1'b0;
      w_busy   = 1'b0;
      w_done   = 1'b0;
      w_io_out = 4'b0000;
      w_io_oe  = 4'b0000;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next = (bus.word_count == 9'd0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            w_busy = 1'b1;
            if (!bus.fifo_empty) begin
               w_rd_en = 1'b1;
               w_next  = S_LOAD;
            end
         end
         S_LOAD: begin
            w_busy = 1'b1;
            w_next = S_SHIFT;
         end
         S_SHIFT: begin
            w_busy   = 1'b1;
            w_io_oe  = r_quad ? 4'b1111 : 4'b0001;
            w_io_out = r_quad ? r_sreg[WORD_W-1 -: 4] : {3'b000, r_sreg[WORD_W-1]};
            if (w_fall && w_last_bit) begin
               w_next = (r_rem == 9'd1) ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg  <= '0;
         r_div   <= '0;
         r_bit   <= '0;
         r_rem   <= '0;
         r_quad  <= 1'b0;
         r_sclk  <= 1'b0;
         r_first <= 1'b0;
         r_stall <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_quad  <= bus.quad_mode;
                  r_rem   <= bus.word_count;
                  r_first <= 1'b1;
                  r_stall <= 1'b0;
               end
            end
            S_FETCH: begin
               if (bus.fifo_empty && !r_first) begin
                  r_stall <= 1'b1;
               end
            end
            S_LOAD: begin
               r_sreg  <= bus.fifo_data;
               r_div   <= '0;
               r_bit   <= '0;
               r_sclk  <= 1'b0;
               r_first <= 1'b0;
            end
            S_SHIFT: begin
               if (w_div_end) begin
                  r_div  <= '0;
                  r_sclk <= ~r_sclk;
                  if (r_sclk) begin
                     r_sreg <= r_quad ? {r_sreg[WORD_W-5:0], 4'b0000}
                                      : {r_sreg[WORD_W-2:0], 1'b0};
                     r_bit  <= r_bit + 5'd1;
                     if (w_last_bit) begin
                        r_rem <= r_rem - 9'd1;
                     end
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.sclk       = r_sclk && (r_state == S_SHIFT);
   assign bus.io_out     = w_io_out;
   assign bus.io_oe      = w_io_oe;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.stall      = r_stall;

endmodule

// File: tb/tb_qspi_tx_serializer.sv
// Purpose : directed + randomized bench for qspi_tx_serializer with a FIFO model and lane-level reference.
// Latency : expected timing derived from word count, lane mode and divider.
// Backpr. : underrun cases delay FIFO pushes and expect sclk held low plus a sticky stall.
module tb_qspi_tx_serializer;

   localparam int D = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   qspi_tx_serializer_if bus();

   qspi_tx_serializer #(.CLK_DIV(D), .WORD_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // FIFO model: bench pushes on negedge, DUT pops on posedge, data registered
   logic [31:0] mem [0:1023];
   int          n_push = 0;
   int          n_pop  = 0;
   logic [31:0] fifo_dat = '0;

   assign bus.fifo_empty = (n_push == n_pop);
   assign bus.fifo_data  = fifo_dat;

   always @(posedge clk) begin
      if (bus.fifo_rd_en && (n_push != n_pop)) begin
         fifo_dat <= mem[n_pop % 1024];
         n_pop    <= n_pop + 1;
      end
   end

   // Monitor: lane values at each sclk rise, pop width, protocol violations
   logic [7:0] rise_v [0:16383];
   int         rise_n = 0;
   int         wide_n = 0;
   int         viol_n = 0;
   logic       prev_sclk = 1'b0;
   logic       prev_rd   = 1'b0;

   always @(negedge clk) begin
      if (bus.sclk && !prev_sclk) begin
         rise_v[rise_n % 16384] <= {bus.io_oe, bus.io_out};
         rise_n <= rise_n + 1;
      end
      if (bus.fifo_rd_en && prev_rd) wide_n <= wide_n + 1;
      if ((bus.fifo_rd_en && bus.fifo_empty) ||
          (!bus.busy && (bus.sclk || bus.io_oe != 4'd0 || bus.io_out != 4'd0 || bus.fifo_rd_en)) ||
          (bus.busy && bus.io_oe == 4'd0 && bus.sclk))
         viol_n <= viol_n + 1;
      prev_sclk <= bus.sclk;
      prev_rd   <= bus.fifo_rd_en;
   end

   logic [31:0] xw [0:255];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[n_push % 1024] = w;
      n_push++;
   endtask

   // Expected {io_oe, io_out} at the k-th rising edge of a word, MSB-first
   function automatic logic [7:0] exp_rise(input logic [31:0] w, input bit quad, input int k);
      logic [31:0] v;
      if (quad) begin
         v = (w >> (28 - 4 * k)) & 32'hF;
         return {4'b1111, v[3:0]};
      end
      v = (w >> (31 - k)) & 32'h1;
      return {4'b0001, 3'b000, v[0]};
   endfunction

   task automatic run_xfer(input bit quad, input int cnt, input int pre, input int late, input bit poke);
      int L, t, r0, p0, w0, v0, idx;
      bit seen;
      L = quad ? 8 : 32;
      for (int i = 0; i < pre; i++) push(xw[i]);
      @(negedge clk);
      r0 = rise_n; p0 = n_pop; w0 = wide_n; v0 = viol_n;
      bus.start      = 1'b1;
      bus.quad_mode  = quad;
      bus.word_count = 9'(cnt);
      @(posedge clk);
      t = 0;
      seen = 1'b0;
      while (!seen && t < 20000) begin
         @(negedge clk);
         if (t == 0) begin
            bus.start      = 1'b0;
            bus.quad_mode  = ~quad;
            bus.word_count = 9'd7;
            chk("stall_clr", bus.stall, 1'b0);
            if (cnt != 0) chk("busy_on", bus.busy, 1'b1);
         end
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            if (late > 0 && t == late)
               for (int i = pre; i < cnt; i++) push(xw[i]);
            if (poke && t == 10) begin
               bus.start      = 1'b1;
               bus.word_count = 9'd5;
            end
            if (poke && t == 11) bus.start = 1'b0;
            @(posedge clk);
            t++;
         end
      end
      chk("done_seen", seen, 1'b1);
      chk("busy_at_done", bus.busy, 1'b0);
      if (late == 0) chk("latency", t, cnt * (2 + 2 * D * L));
      chk("stall", bus.stall, (late > 0) ? 1'b1 : 1'b0);
      chk("pops", n_pop - p0, cnt);
      chk("pop_width", wide_n - w0, 0);
      chk("rises", rise_n - r0, cnt * L);
      for (int i = 0; i < cnt; i++)
         for (int k = 0; k < L; k++) begin
            idx = (r0 + i * L + k) % 16384;
            chk("lane", rise_v[idx], exp_rise(xw[i], quad, k));
         end
      // start landing on the DONE cycle must be ignored
      bus.start      = 1'b1;
      bus.word_count = 9'd3;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_in_done", {bus.busy, bus.done}, 2'b00);
      chk("protocol", viol_n - v0, 0);
   endtask

   initial begin
      int p0, c;
      bit q;
      bus.start      = 1'b0;
      bus.quad_mode  = 1'b0;
      bus.word_count = 9'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {bus.sclk, bus.io_out, bus.io_oe, bus.fifo_rd_en, bus.busy, bus.done, bus.stall}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // quad, one word
      xw[0] = 32'hA5000001;
      run_xfer(1'b1, 1, 1, 0, 1'b0);

      // single, two words
      xw[0] = 32'h80000001;
      xw[1] = 32'hFFFFFFFF;
      run_xfer(1'b0, 2, 2, 0, 1'b0);

      // underrun: one word preloaded, the rest 50 cycles late
      xw[0] = 32'h12345678; xw[1] = 32'h9ABCDEF0; xw[2] = 32'h0F1E2D3C;
      run_xfer(1'b1, 3, 1, 50, 1'b0);

      // zero-length transfer
      run_xfer(1'b1, 0, 0, 0, 1'b0);

      // start pulsed mid-shift is ignored
      xw[0] = $urandom; xw[1] = $urandom;
      run_xfer(1'b1, 2, 2, 0, 1'b1);

      // reset mid-shift: one of two words available, abort inside the first word
      push(32'hC3C3C3C3);
      p0 = n_pop;
      @(negedge clk);
      bus.start = 1'b1; bus.quad_mode = 1'b1; bus.word_count = 9'd2;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("reset_mid", {bus.sclk, bus.io_out, bus.io_oe, bus.fifo_rd_en, bus.busy, bus.done, bus.stall}, 0);
      repeat (5) @(negedge clk);
      chk("reset_hold", {bus.sclk, bus.io_out, bus.io_oe, bus.fifo_rd_en, bus.busy, bus.done, bus.stall}, 0);
      chk("reset_pops", n_pop - p0, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // randomized transfers
      for (int n = 0; n < 6; n++) begin
         q = 1'($urandom_range(0, 1));
         c = $urandom_range(1, 3);
         for (int i = 0; i < c; i++) xw[i] = $urandom;
         if (c >= 2 && $urandom_range(0, 1) == 1) run_xfer(q, c, 1, 150, 1'b0);
         else                                     run_xfer(q, c, c, 0, 1'b0);
      end

      // maximum count
      for (int i = 0; i < 256; i++) xw[i] = $urandom;
      run_xfer(1'b1, 256, 256, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
